// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/gnt/rvalid memory port, prefetch FIFO, redirect flush.
// Optional misaligned-redirect trap is built when FETCH_ALIGN_CHECK_EN is defined.

module instr_fetch #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR       = '0,
    parameter int unsigned           FIFO_DEPTH      = 2,
    parameter int unsigned           MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  instr_req_o,
    output logic [DATA_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0] instr_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                  fetch_misaligned_o
`endif
);

    localparam int unsigned FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TAW-1:0]        TAG_LAST   = TAW'(MAX_OUTSTANDING - 1);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_fetch_addr;
    logic [OCW-1:0]        r_outstanding, r_discard;
    logic [OCW-1:0]        w_outstanding_nxt, w_discard_nxt, w_live;
    logic [31:0]           w_occupancy;

    logic [DATA_WIDTH-1:0] r_tag_pc [MAX_OUTSTANDING];
    logic [TAW-1:0]        r_tag_wptr, r_tag_rptr;

    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [FAW-1:0]        r_fifo_wptr, r_fifo_rptr;
    logic [FCW-1:0]        r_fifo_cnt;

    logic w_gnt_acc, w_push, w_pop, w_req_block;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end

    assign w_req_block        = r_misaligned;
    assign fetch_misaligned_o = r_misaligned;
`else
    assign w_req_block = 1'b0;
`endif

    // Live requests (not marked for discard) still need FIFO room on return.
    always_comb begin
        w_live      = r_outstanding - r_discard;
        w_occupancy = 32'(w_live) + 32'(r_fifo_cnt);
        instr_req_o = (r_state != S_BOOT) && !w_req_block &&
                      (w_occupancy < FIFO_DEPTH) &&
                      (32'(r_outstanding) < MAX_OUTSTANDING);
    end

    assign w_gnt_acc     = instr_req_o & instr_gnt_i;
    assign instr_addr_o  = r_fetch_addr;
    assign instr_valid_o = (r_fifo_cnt != '0);
    assign instr_o       = r_fifo_data[r_fifo_rptr];
    assign instr_pc_o    = r_fifo_pc[r_fifo_rptr];
    assign w_push        = instr_rvalid_i && (r_discard == '0) && !redirect_i;
    assign w_pop         = instr_valid_o && instr_ready_i && !redirect_i;

    // A redirect marks every request still in flight after this edge as stale.
    always_comb begin
        w_outstanding_nxt = r_outstanding + OCW'(w_gnt_acc) - OCW'(instr_rvalid_i);
        w_discard_nxt     = r_discard;
        if (redirect_i) begin
            w_discard_nxt = w_outstanding_nxt;
        end else if (instr_rvalid_i && (r_discard != '0)) begin
            w_discard_nxt = r_discard - OCW'(1);
        end

        w_state_nxt = r_state;
        unique case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (redirect_i && (w_outstanding_nxt != '0)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_discard_nxt == '0) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_fetch_addr  <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_tag_wptr    <= '0;
            r_tag_rptr    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;

            if (redirect_i) begin
                r_fetch_addr <= redirect_pc_i & ALIGN_MASK;
            end else if (w_gnt_acc) begin
                r_fetch_addr <= r_fetch_addr + DATA_WIDTH'(4);
            end

            if (w_gnt_acc) begin
                r_tag_pc[r_tag_wptr] <= r_fetch_addr;
                r_tag_wptr <= (r_tag_wptr == TAG_LAST) ? '0 : r_tag_wptr + TAW'(1);
            end
            if (instr_rvalid_i) begin
                r_tag_rptr <= (r_tag_rptr == TAG_LAST) ? '0 : r_tag_rptr + TAW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_wptr <= '0;
            r_fifo_rptr <= '0;
            r_fifo_cnt  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (redirect_i) begin
            r_fifo_wptr <= '0;
            r_fifo_rptr <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_fifo_wptr] <= instr_rdata_i;
                r_fifo_pc[r_fifo_wptr]   <= r_tag_pc[r_tag_rptr];
                r_fifo_wptr              <= r_fifo_wptr + FAW'(1);
            end
            if (w_pop) begin
                r_fifo_rptr <= r_fifo_rptr + FAW'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + FCW'(w_push) - FCW'(w_pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model plus a PC-stream reference.
// Honours FETCH_ALIGN_CHECK_EN when the design is built with it.

module tb_instr_fetch;

    localparam int unsigned MAXO = 2;
    localparam int unsigned FD   = 2;
    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misaligned_o;
`endif

    instr_fetch #(
        .DATA_WIDTH(32),
        .BOOT_ADDR(BOOT),
        .FIFO_DEPTH(FD),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o(instr_o),
        .instr_pc_o(instr_pc_o),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misaligned_o(fetch_misaligned_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } resp_t;

    resp_t       pend[$];
    int unsigned edge_n = 0;
    int unsigned last_due = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned npops = 0;
    logic [31:0] exp_pc = BOOT;

    int unsigned gnt_mode = 0;     // 0 always, 1 never, 2 random
    int unsigned ready_mode = 1;   // 0 stall, 1 always, 2 random
    bit          rand_delay = 0;
    int unsigned fixed_delay = 1;
    int unsigned slow_delay = 2;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive_inputs();
        bit g;
        instr_rvalid_i = (pend.size() > 0) && (pend[0].due <= edge_n + 1);
        instr_rdata_i  = instr_rvalid_i ? mem_word(pend[0].addr) : $urandom;
        case (gnt_mode)
            0:       g = 1'b1;
            1:       g = 1'b0;
            default: g = ($urandom_range(0, 3) != 0);
        endcase
        instr_gnt_i = instr_req_o && g;
        case (ready_mode)
            0:       instr_ready_i = 1'b0;
            1:       instr_ready_i = 1'b1;
            default: instr_ready_i = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic tick();
        logic        p_rst, p_req, p_gnt, p_rvalid, p_redir, p_pop, p_valid, p_ready;
        logic [31:0] p_addr, p_pc, p_instr, p_target;
        int unsigned d, due;
        p_rst    = rst;
        p_req    = instr_req_o;
        p_gnt    = instr_gnt_i;
        p_rvalid = instr_rvalid_i;
        p_redir  = redirect_i;
        p_valid  = instr_valid_o;
        p_ready  = instr_ready_i;
        p_pop    = instr_valid_o && instr_ready_i && !redirect_i && !rst;
        p_addr   = instr_addr_o;
        p_pc     = instr_pc_o;
        p_instr  = instr_o;
        p_target = redirect_pc_i;
        @(posedge clk);
        #1;
        edge_n++;
        redirect_i = 1'b0;
        if (p_rst) begin
            pend.delete();
            last_due = 0;
            exp_pc   = BOOT;
        end else begin
            if (p_rvalid) void'(pend.pop_front());
            if (p_req && p_gnt) begin
                if (rand_delay)              d = $urandom_range(1, 3);
                else if (p_addr == slow_addr) d = slow_delay;
                else                          d = fixed_delay;
                due = edge_n + d;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{p_addr, due});
            end
            check("outstanding_cap", 32'(pend.size() <= MAXO), 32'd1);
            if (p_pop) begin
                check("pop_pc", p_pc, exp_pc);
                check("pop_instr", p_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                npops++;
            end
            if (p_redir) begin
                exp_pc = p_target & 32'hFFFF_FFFC;
                check("flush_valid", instr_valid_o, 32'd0);
            end else begin
                if (p_req && !p_gnt) check("addr_hold", instr_addr_o, p_addr);
                if (p_valid && !p_ready) begin
                    check("head_valid_hold", instr_valid_o, 32'd1);
                    check("head_pc_hold", instr_pc_o, p_pc);
                    check("head_instr_hold", instr_o, p_instr);
                end
            end
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        drive_inputs();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        int unsigned base;
        bit          found;
        rst = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
        instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        // Reset state and first-fetch latency with gnt=1, rvalid one cycle later.
        gnt_mode = 0; ready_mode = 1; fixed_delay = 1;
        do_reset();
        check("rst_req", instr_req_o, 32'd0);
        check("rst_addr", instr_addr_o, BOOT);
        check("rst_valid", instr_valid_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_misaligned", fetch_misaligned_o, 32'd0);
`endif
        tick();
        check("run_req", instr_req_o, 32'd1);
        check("run_addr", instr_addr_o, 32'h0);
        tick();
        check("lat_valid_early", instr_valid_o, 32'd0);
        tick();
        check("lat_valid", instr_valid_o, 32'd1);
        check("lat_pc", instr_pc_o, 32'h0);
        check("lat_instr", instr_o, mem_word(32'h0));
        base = npops;
        run(8);
        check("seq_progress", 32'(npops - base >= 3), 32'd1);

        // Back-pressure: FIFO fills, issue stops, head holds PC 0.
        ready_mode = 0;
        do_reset();
        run(12);
        check("bp_req", instr_req_o, 32'd0);
        check("bp_valid", instr_valid_o, 32'd1);
        check("bp_head", instr_pc_o, 32'h0);
        ready_mode = 1;
        drive_inputs();
        base = npops;
        run(8);
        check("bp_drain", 32'(npops - base >= 3), 32'd1);

        // Grant withheld: address held at 0x4.
        do_reset();
        tick();
        tick();
        gnt_mode = 1;
        drive_inputs();
        for (int unsigned i = 0; i < 3; i++) begin
            check("stall_addr", instr_addr_o, 32'h4);
            check("stall_req", instr_req_o, 32'd1);
            tick();
        end
        gnt_mode = 0;
        drive_inputs();
        tick();
        check("stall_release", instr_addr_o, 32'h8);

        // Redirect with two requests in flight.
        fixed_delay = 3;
        do_reset();
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 2 && !instr_rvalid_i) begin
                found = 1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
            end
            tick();
        end
        check("redir_setup", 32'(found), 32'd1);
        base = npops;
        run(20);
        check("redir_progress", 32'(npops - base >= 2), 32'd1);

        // Redirect coinciding with gnt of 0x8 and rvalid of 0x4.
        fixed_delay = 1; slow_addr = 32'h4; slow_delay = 2;
        do_reset();
        found = 0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            if (instr_req_o && instr_gnt_i && instr_addr_o == 32'h8 && instr_rvalid_i &&
                pend.size() > 0 && pend[0].addr == 32'h4) begin
                found = 1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
            end
            tick();
        end
        check("coincide_setup", 32'(found), 32'd1);
        base = npops;
        run(15);
        check("coincide_progress", 32'(npops - base >= 2), 32'd1);
        slow_addr = 32'hFFFF_FFFF;

        // Redirect to an unaligned target.
        do_reset();
        run(6);
        redirect_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_flag", fetch_misaligned_o, 32'd1);
        check("mis_req", instr_req_o, 32'd0);
        run(6);
        check("mis_req_hold", instr_req_o, 32'd0);
        check("mis_valid", instr_valid_o, 32'd0);
        check("mis_flag_hold", fetch_misaligned_o, 32'd1);
`else
        base = npops;
        run(15);
        check("unaligned_progress", 32'(npops - base >= 2), 32'd1);
`endif

        // Randomized traffic against the PC-stream model.
        gnt_mode = 2; ready_mode = 2; rand_delay = 1;
        do_reset();
        for (int unsigned i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                redirect_i = 1'b1;
                redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                            : $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
                redirect_pc_i = redirect_pc_i & 32'hFFFF_FFFC;
`endif
            end
            tick();
        end
        gnt_mode = 0; ready_mode = 1; rand_delay = 0; fixed_delay = 1;
        drive_inputs();
        base = npops;
        run(30);
        check("final_progress", 32'(npops - base >= 5), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
